// File: rtl/carry_skip_sub_seq_if.sv
// Operand/result handshake bundle for the sequential carry-skip subtractor.
// CSS_SKIP_COUNT_EN adds the skip_cnt result field.
interface carry_skip_sub_seq_if #(
    parameter int WIDTH = 16
);
    localparam int NBLK = WIDTH / 4;
    localparam int CW   = $clog2(NBLK + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             busy;
`ifdef CSS_SKIP_COUNT_EN
    logic [CW-1:0]    skip_cnt;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, busy, skip_cnt
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, busy, skip_cnt
    );
`else
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, busy
    );
`endif
endinterface

// File: rtl/carry_skip_sub_seq.sv
// Sequential carry-skip subtractor: a - b - bin, one 4-bit block per clock.
// Optional: CSS_SKIP_COUNT_EN adds a per-operation skip-path block counter.
module carry_skip_sub_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    carry_skip_sub_seq_if.slave bus
);
    localparam int NBLK = WIDTH / 4;
    localparam int IW   = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int MSB  = WIDTH - 1;
    localparam logic [IW-1:0] LAST = IW'(NBLK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] nb_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_n;
    logic             carry;
    logic             carry_n;
    logic [IW-1:0]    idx;
    logic             bout_q;
    logic             ovf_q;
    logic             ovf_n;
    logic             accept;
    logic             last;

    logic [3:0]       blk_a;
    logic [3:0]       blk_b;
    logic [3:0]       blk_p;
    logic [3:0]       blk_s;
    logic [4:0]       rc;
    logic             skip;

    assign accept = bus.in_valid && (state == IDLE);
    assign last   = (idx == LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and handshake/status outputs.
    always_comb begin
        state_n       = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // One block: 4-cell ripple, with the carry bypassed when all bits propagate.
    always_comb begin
        blk_a = a_q[{idx, 2'b00} +: 4];
        blk_b = nb_q[{idx, 2'b00} +: 4];
        blk_p = blk_a ^ blk_b;
        rc    = '0;
        blk_s = '0;
        rc[0] = carry;
        for (int i = 0; i < 4; i++) begin
            blk_s[i]  = blk_p[i] ^ rc[i];
            rc[i + 1] = (blk_a[i] & blk_b[i]) | (blk_p[i] & rc[i]);
        end
        skip    = &blk_p;
        carry_n = skip ? carry : rc[4];
        diff_n  = diff_q;
        diff_n[{idx, 2'b00} +: 4] = blk_s;
        // b's sign is the complement of the stored ~b sign bit.
        ovf_n = (a_q[MSB] != ~nb_q[MSB]) && (blk_s[3] != a_q[MSB]);
    end

    // Operand capture and block-by-block result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            nb_q   <= '0;
            diff_q <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            a_q   <= bus.a;
            nb_q  <= ~bus.b;
            carry <= ~bus.bin;
            idx   <= '0;
        end else if (state == RUN) begin
            diff_q <= diff_n;
            carry  <= carry_n;
            idx    <= last ? '0 : idx + IW'(1);
            if (last) begin
                bout_q <= ~carry_n;
                ovf_q  <= ovf_n;
            end
        end
    end

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;

`ifdef CSS_SKIP_COUNT_EN
    localparam int CW = $clog2(NBLK + 1);

    logic [CW-1:0] skip_q;

    // Count blocks of the current operation that took the bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_q <= '0;
        end else if (accept) begin
            skip_q <= '0;
        end else if (state == RUN) begin
            skip_q <= skip_q + CW'(skip);
        end
    end

    assign bus.skip_cnt = skip_q;
`endif
endmodule

// File: tb/tb_carry_skip_sub_seq.sv
// Scoreboard bench for carry_skip_sub_seq at WIDTH=16.
// Honors CSS_SKIP_COUNT_EN when defined.
module tb_carry_skip_sub_seq;
    localparam int WIDTH = 16;

    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        ov;
        int          sk;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    carry_skip_sub_seq_if #(.WIDTH(WIDTH)) bus ();

    carry_skip_sub_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    exp_t sbq[$];
    exp_t mon_e;
    int   vec = 0;
    int   mis = 0;

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic bin);
        exp_t e;
        int   ua, ub, r, sa, sb, sr;
        logic [3:0] na, nbv;
        ua = int'(a);
        ub = int'(b);
        r  = ua - ub - int'(bin);
        e.d  = r[15:0];
        e.bo = (r < 0);
        sa = int'($signed(a));
        sb = int'($signed(b));
        sr = sa - sb - int'(bin);
        e.ov = (sr < -32768) || (sr > 32767);
        e.sk = 0;
        for (int k = 0; k < 4; k++) begin
            na  = a[4*k +: 4];
            nbv = b[4*k +: 4];
            if (na == nbv) e.sk++;
        end
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare whenever a result is presented, pop on handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sbq[0];
                check("diff", 32'(bus.diff), 32'(mon_e.d));
                check("bout", 32'(bus.bout), 32'(mon_e.bo));
                check("ovf", 32'(bus.ovf), 32'(mon_e.ov));
`ifdef CSS_SKIP_COUNT_EN
                check("skip_cnt", 32'(bus.skip_cnt), 32'(mon_e.sk));
`endif
                if (bus.out_ready === 1'b1) void'(sbq.pop_front());
            end
        end
    end

    task automatic scramble();
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.bin      = 1'($urandom);
        bus.in_valid = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic issue(logic [15:0] a, logic [15:0] b, logic bin);
        wait_idle();
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        bus.in_valid = 1'b1;
        sbq.push_back(model(a, b, bin));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_op(logic [15:0] a, logic [15:0] b, logic bin, int stall);
        int n;
        issue(a, b, bin);
        for (int i = 0; i < 4; i++) begin
            check("run_busy", 32'(bus.busy), 32'd1);
            check("run_no_valid", 32'(bus.out_valid), 32'd0);
            check("run_no_ready", 32'(bus.in_ready), 32'd0);
            scramble();
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("latency", 32'(bus.out_valid), 32'd1);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.out_valid !== 1'b1) begin
            check("out_valid_timeout", 32'd0, 32'd1);
            void'(sbq.pop_back());
            return;
        end
        for (int s = 0; s < stall; s++) begin
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            scramble();
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_hs_valid", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_bout", 32'(bus.bout), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
`ifdef CSS_SKIP_COUNT_EN
        check("rst_skip_cnt", 32'(bus.skip_cnt), 32'd0);
`endif
    endtask

    initial begin
        logic [15:0] ra, rb, mask;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_op(16'h1234, 16'h0034, 1'b0, 0);
        run_op(16'h0000, 16'h0001, 1'b0, 1);
        run_op(16'h8000, 16'h0001, 1'b0, 2);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);
        run_op(16'h7FFF, 16'hFFFF, 1'b1, 0);
        run_op(16'h8000, 16'h0000, 1'b1, 0);
        run_op(16'hBEEF, 16'h1357, 1'b1, 5);

        // Abort after two RUN cycles.
        issue(16'hA5A5, 16'h1111, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        void'(sbq.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("abort_no_valid", 32'(bus.out_valid), 32'd0);
            @(posedge clk); #1;
        end
        run_op(16'h0005, 16'h0003, 1'b0, 0);

        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                mask = 16'($urandom) & 16'h0F0F;
                rb   = ra ^ mask;
            end
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
